dm_byte_mem: RTL and testbench

- Word-organised data memory directly downstream of the store-data alignment stage in the MEM pipeline stage.
- Consumes the lane-aligned write word and 4-bit byte-enable, commits only the enabled byte lanes on the clock edge, and returns the full 32-bit word combinationally for loads.
- Flags illegal byte-enable patterns and out-of-range addresses in a sticky error register.
- Counts committed stores for the verification bench.

---
 rtl/dm_byte_mem.sv | 120 ++++++++++++
 tb/tb_dm_byte_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_byte_mem.sv
// Word-organised data memory for the MEM stage: byte-lane merged stores,
// combinational loads, sticky first-fault capture and a committed-store counter.
module dm_byte_mem #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [3:0]  err_be,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  typedef enum logic {
    CLEAN   = 1'b0,
    FAULTED = 1'b1
  } err_state_e;

  err_state_e        state;
  err_state_e        state_next;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              be_legal;
  logic              commit;
  logic              fault;
  logic [31:0]       lane_mask;
  logic [31:0]       rd_words [DEPTH];

  // Unsigned wrap of the subtraction makes one compare cover both range bounds.
  assign offset   = addr - BASE;
  assign idx      = offset[ADDR_W+1:2];
  assign in_range = ({1'b0, offset} < SPAN);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    be_legal = 1'b0;
    case (byte_en)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
      default:                            be_legal = 1'b0;
    endcase
  end

  // An all-zero byte_en is a silent no-op even when the address is bad.
  assign commit    = we && be_legal && in_range;
  assign fault     = we && (byte_en != 4'b0000) && (!be_legal || !in_range);
  assign lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic [31:0] word_q;

    // NOTE: storage must clear asynchronously on reset, which no RAM macro offers, so each word is its own register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= '0;
      end else if (commit && (idx == ADDR_W'(w))) begin
        // NOTE: non-blocking so every reader this edge still sees the pre-store word.
        word_q <= (word_q & ~lane_mask) | (wdata & lane_mask);
      end
    end

    assign rd_words[w] = word_q;
  end

  // Loads are not bypassed: a same-cycle store shows up only after the edge.
  always_comb begin
    rdata = '0;
    if (!reset && in_range) begin
      rdata = rd_words[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAN:   if (fault) state_next = FAULTED;
      FAULTED: state_next = FAULTED;
      default: state_next = CLEAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr <= '0;
      err_be   <= '0;
    end else if ((state == CLEAN) && fault) begin
      err_addr <= addr;
      err_be   <= byte_en;
    end
  end

  assign err = (state == FAULTED);

endmodule

// File: tb/tb_dm_byte_mem.sv
// Scoreboard bench for dm_byte_mem: a reference word model predicts loads,
// error capture and the store count.
module tb_dm_byte_mem;

  localparam int unsigned ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] SIZE   = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] err_addr;
  logic [3:0]  err_be;
  logic [31:0] wr_count;

  dm_byte_mem #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .byte_en  (byte_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .err      (err),
    .err_addr (err_addr),
    .err_be   (err_be),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [int];
  logic [31:0] model_cnt;
  logic        model_err;
  logic [31:0] model_err_addr;
  logic [3:0]  model_err_be;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SIZE);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int key;
    if (!model_in_range(a)) return 32'h0;
    key = int'((a - BASE) >> 2);
    if (model_mem.exists(key)) return model_mem[key];
    return 32'h0;
  endfunction

  function automatic bit model_legal(input logic [3:0] be);
    return be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  task automatic model_clear();
    model_mem.delete();
    model_cnt      = 0;
    model_err      = 0;
    model_err_addr = 0;
    model_err_be   = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] old;
    logic [31:0] merged;
    if (be == 4'b0000) return;
    if (model_legal(be) && model_in_range(a)) begin
      old = model_rd(a);
      merged = old;
      for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = d[8*i +: 8];
      model_mem[int'((a - BASE) >> 2)] = merged;
      model_cnt = model_cnt + 1;
    end else if (!model_err) begin
      model_err      = 1;
      model_err_addr = a;
      model_err_be   = be;
    end
  endtask

  task automatic push_rd(input string tag);
    exp_q.push_back(model_rd(addr));
    tag_q.push_back(tag);
  endtask

  task automatic pop_rd();
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  task automatic read(input string tag, input logic [31:0] a);
    addr = a;
    push_rd(tag);
    #1;
    pop_rd();
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    we = 1; addr = a; byte_en = be; wdata = d;
    @(posedge clk);
    model_edge(a, be, d);
    #1;
    we = 0;
    push_rd(tag);
    #1;
    pop_rd();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err"},      {31'h0, err},     {31'h0, model_err});
    check({tag, "_err_addr"}, err_addr,         model_err_addr);
    check({tag, "_err_be"},   {28'h0, err_be},  {28'h0, model_err_be});
    check({tag, "_wr_count"}, wr_count,         model_cnt);
  endtask

  initial begin
    reset = 1; we = 0; addr = 0; byte_en = 0; wdata = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    read("rst_rd_0", 32'h0);
    read("rst_rd_10", 32'h10);
    read("rst_rd_3ffc", 32'h3FFC);
    check_status("rst");

    store("merge_1", 32'h4, 4'b1111, 32'h1122_3344);
    check(".merge_1_val", rdata, 32'h1122_3344);
    store("merge_2", 32'h4, 4'b0010, 32'h0000_AA00);
    check(".merge_2_val", rdata, 32'h1122_AA44);
    store("merge_3", 32'h4, 4'b1100, 32'hBEEF_0000);
    check(".merge_3_val", rdata, 32'hBEEF_AA44);
    check_status("merge");

    store("rdw_seed", 32'h8, 4'b1111, 32'hCAFE_F00D);
    @(negedge clk);
    we = 1; addr = 32'h8; byte_en = 4'b1111; wdata = 32'h1234_5678;
    push_rd("rdw_before");
    #1;
    pop_rd();
    check(".rdw_before_val", rdata, 32'hCAFE_F00D);
    @(posedge clk);
    model_edge(32'h8, 4'b1111, 32'h1234_5678);
    #1;
    we = 0;
    push_rd("rdw_after");
    #1;
    pop_rd();
    check(".rdw_after_val", rdata, 32'h1234_5678);

    store("noop_be0", 32'h4, 4'b0000, 32'h7777_7777);
    @(negedge clk);
    we = 0; addr = 32'h4; byte_en = 4'b1111; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    read("idle_rd", 32'h4);
    check(".idle_val", rdata, 32'hBEEF_AA44);
    check_status("noop");

    store("ill_be", 32'h20, 4'b0110, 32'hFFFF_FFFF);
    check_status("ill_be");
    store("oor", 32'h0004_0000, 4'b1111, 32'h5555_5555);
    check_status("oor");
    check(".oor_sticky_addr", err_addr, 32'h20);
    read("ill_rd_20", 32'h20);
    read("edge_last", 32'h3FFC);
    read("edge_past", 32'h4000);

    store("edge_top", 32'h3FFC, 4'b1000, 32'hAB00_0000);
    check_status("pre_rst");

    @(negedge clk);
    we = 1; addr = 32'h4; byte_en = 4'b1111; wdata = 32'h0000_0055;
    #2;
    reset = 1;
    model_clear();
    #1;
    push_rd("mid_rst_rd");
    #0 pop_rd();
    check_status("mid_rst");
    @(posedge clk);
    #1;
    check_status("rst_edge");
    @(negedge clk);
    reset = 0; we = 0;
    read("post_rst_4", 32'h4);
    read("post_rst_8", 32'h8);
    read("post_rst_3ffc", 32'h3FFC);
    check_status("post_rst");

    store("post_store", 32'h3FFC, 4'b0001, 32'h0000_00C3);
    check_status("post_store");

    if (exp_q.size() != 0) check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
